mips_alu: RTL and testbench
===========================

MIPS_ALU -- requirements
Module: MIPSALU

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ALUctl  input  4  operation select, sampled each rising clk edge.
REQ-006 A  input  32  operand A; two's-complement where signed.
REQ-007 B  input  32  operand B; two's-complement where signed.
REQ-008 ALUOut  output  32  registered result.
REQ-009 Zero  output  1  high when ALUOut == 32'h0.

Function
REQ-010 The block SHALL decode ALUctl per the following table:
- 4'h0: AND, A & B.
- 4'h1: OR, A | B.
- 4'h2: ADD, A + B, modulo 2^32.
- 4'h6: SUB, A - B, modulo 2^32.
- 4'h7: SLT, 32'h1 if signed(A) < signed(B), else 32'h0.
- 4'hC: NOR, ~(A | B).
REQ-011 The block SHALL produce 32'h0 for every other ALUctl value (3,4,5,8,9,A,B,D,E,F); these codes have no side effects.
REQ-012 ADD/SUB SHALL wrap silently; carry-out and overflow are discarded and no flag or exception is raised.
REQ-013 SLT SHALL compare correctly across the sign boundary, i.e. use the true sign of A-B, not bit 31 of the wrapped difference (e.g. 32'h80000000 < 32'h7FFFFFFF gives 1).
REQ-014 The result SHALL be computed combinationally from ALUctl/A/B and registered into ALUOut on every rising clk edge.
- Latency: exactly 1 cycle.
- Throughput: 1 operation per cycle.
- No enable or handshake.
REQ-015 Zero SHALL be a combinational decode of the registered ALUOut, so it is always consistent with ALUOut in the same cycle.
REQ-016 Input changes between clock edges SHALL NOT affect ALUOut until the next rising edge.
REQ-017 The block SHALL have no other internal state.

Reset
REQ-018 While reset is high, ALUOut SHALL be 32'h0 immediately, independent of clk, and consequently Zero SHALL be 1.
REQ-019 On reset deassertion, the first rising clk edge SHALL load the result for the ALUctl/A/B present at that edge.
REQ-020 Reset asserted mid-operation SHALL discard the pending result; no partial or stale value appears after release.

Verification
REQ-021 Bench SHALL cover reset: assert reset with ALUctl=0, A=B=0 -> ALUOut=0, Zero=1, with no clock required; release, then a clock edge -> ALUOut=0, Zero=1.
REQ-022 Bench SHALL cover AND:
- ALUctl=0, A=C, B=4 -> after 1 edge, ALUOut=4, Zero=0.
- Then A=F, B=6 -> ALUOut=6.
REQ-023 Bench SHALL cover SLT:
- ALUctl=7, A=F, B=6 -> ALUOut=0, Zero=1.
- Then A=1 -> ALUOut=1, Zero=0.
- A=FFFFFFFF, B=1 -> ALUOut=1 (signed comparison).
REQ-024 Bench SHALL cover arithmetic wrap:
- ALUctl=2, A=FFFFFFFF, B=1 -> ALUOut=0, Zero=1.
- ALUctl=6, A=5, B=5 -> ALUOut=0, Zero=1.
- ALUctl=6, A=0, B=1 -> ALUOut=FFFFFFFF.
REQ-025 Bench SHALL cover OR/NOR/undefined codes:
- ALUctl=1, A=F0, B=0F -> FF.
- ALUctl=C, A=B=0 -> FFFFFFFF.
- ALUctl=3, any operands -> 0, Zero=1.
REQ-026 Bench SHALL cover reset mid-stream: ALUOut=6 held, pulse reset between edges -> ALUOut=0 at once and stays 0 until the first edge after release.

Source files
------------

// File: rtl/mips_alu.sv
// MIPS-style 32-bit ALU. The result is computed combinationally from ALUctl/A/B
// and registered into ALUOut on every rising edge. Zero is decoded from the registered result.
module mips_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUctl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUOut,
  output logic        Zero
);

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_NOR = 4'hC;

  logic [31:0] alu_d;
  logic [31:0] alu_q;
  logic        slt_lt;

  // Signed compare uses the true sign, not bit 31 of a wrapped difference.
  assign slt_lt = ($signed(A) < $signed(B));

  always_comb begin
    alu_d = 32'h0;
    case (ALUctl)
      OP_AND:  alu_d = A & B;
      OP_OR:   alu_d = A | B;
      OP_ADD:  alu_d = A + B;
      OP_SUB:  alu_d = A - B;
      OP_SLT:  alu_d = {31'h0, slt_lt};
      OP_NOR:  alu_d = ~(A | B);
      default: alu_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q <= 32'h0;
    end else begin
      alu_q <= alu_d;
    end
  end

  assign ALUOut = alu_q;
  assign Zero   = (alu_q == 32'h0);

endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: reset, each opcode, wrap/sign boundaries,
// input changes between edges, and a reset pulse in the middle of the stream.
module tb_mips_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUOut;
  logic        Zero;

  int n_total;
  int n_pass;

  mips_alu dut (
    .clk    (clk),
    .reset  (reset),
    .ALUctl (ALUctl),
    .A      (A),
    .B      (B),
    .ALUOut (ALUOut),
    .Zero   (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_out);
    check({tag, "_out"}, ALUOut, exp_out);
    check({tag, "_zero"}, {31'h0, Zero}, {31'h0, (exp_out == 32'h0)});
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    ALUctl = ctl;
    A      = a;
    B      = b;
  endtask

  // Drive operands, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    drive(ctl, a, b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    drive(4'h0, 32'h0, 32'h0);

    // Reset holds ALUOut at zero before any clock edge.
    #2;
    check_out("reset_noclk", 32'h0);

    @(negedge clk);
    reset = 1'b0;
    step(4'h0, 32'h0, 32'h0);
    check_out("reset_release", 32'h0);

    // AND
    step(4'h0, 32'hC, 32'h4);
    check_out("and_c_4", 32'h4);
    step(4'h0, 32'hF, 32'h6);
    check_out("and_f_6", 32'h6);

    // Inputs changed between edges must not show until the next edge.
    drive(4'h1, 32'hFFFF_0000, 32'h0000_FFFF);
    #2;
    check_out("hold_between_edges", 32'h6);

    // SLT
    step(4'h7, 32'hF, 32'h6);
    check_out("slt_f_6", 32'h0);
    step(4'h7, 32'h1, 32'h6);
    check_out("slt_1_6", 32'h1);
    step(4'h7, 32'hFFFF_FFFF, 32'h1);
    check_out("slt_neg1_1", 32'h1);
    step(4'h7, 32'h8000_0000, 32'h7FFF_FFFF);
    check_out("slt_min_max", 32'h1);
    step(4'h7, 32'h7FFF_FFFF, 32'h8000_0000);
    check_out("slt_max_min", 32'h0);
    step(4'h7, 32'h5, 32'h5);
    check_out("slt_equal", 32'h0);

    // Arithmetic wrap
    step(4'h2, 32'hFFFF_FFFF, 32'h1);
    check_out("add_wrap", 32'h0);
    step(4'h2, 32'h1234_5678, 32'h1111_1111);
    check_out("add_plain", 32'h2345_6789);
    step(4'h6, 32'h5, 32'h5);
    check_out("sub_equal", 32'h0);
    step(4'h6, 32'h0, 32'h1);
    check_out("sub_wrap", 32'hFFFF_FFFF);
    step(4'h6, 32'h8000_0000, 32'h1);
    check_out("sub_ovf", 32'h7FFF_FFFF);

    // OR / NOR / undefined codes
    step(4'h1, 32'hF0, 32'h0F);
    check_out("or_f0_0f", 32'hFF);
    step(4'hC, 32'h0, 32'h0);
    check_out("nor_zero", 32'hFFFF_FFFF);
    step(4'hC, 32'hF0F0_0000, 32'h0000_0F0F);
    check_out("nor_mixed", 32'h0F0F_F0F0);
    step(4'h3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    check_out("undef_3", 32'h0);
    step(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_out("undef_8", 32'h0);
    step(4'hF, 32'h1234_5678, 32'h8765_4321);
    check_out("undef_f", 32'h0);

    // Reset pulse mid-stream while ALUOut holds 6.
    step(4'h0, 32'hF, 32'h6);
    check_out("pre_midreset", 32'h6);
    #1;
    reset = 1'b1;
    #1;
    check_out("midreset_immediate", 32'h0);
    @(posedge clk);
    #1;
    check_out("midreset_edge_held", 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check_out("midreset_released", 32'h0);
    @(posedge clk);
    #1;
    check_out("midreset_first_edge", 32'h6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
